// File: rtl/cpu_types_pkg.sv
// Shared CPU-level types used by the memory-control level.
// Holds the data word type, the RAM handshake state encoding seen on
// ramstate, the arbiter ownership states, and the default load value
// returned on an aborted memory access.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_D = 2'd1,
        GNT_I = 2'd2
    } arbstate_t;

    localparam word_t ERR_WORD_DEFAULT = 32'hBAD1BAD1;

endpackage

// File: rtl/arb_watchdog.sv
// Per-access watchdog for the memory arbiter.
// Counts cycles while an access is granted and flags expiry in the cycle the
// count reaches TIMEOUT-1, i.e. the TIMEOUT-th granted cycle of one access.
// Ports:
//   clk_i     clock, rising edge
//   rst_i     synchronous active-high reset
//   clr_i     restart the count (grant change, completion, abort)
//   en_i      an access is currently granted
//   expire_o  access has waited its full budget this cycle
module arb_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wd_cnt_q;
    logic [CW-1:0] wd_cnt_d;

    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (clr_i) begin
            wd_cnt_d = '0;
        end else if (en_i) begin
            wd_cnt_d = wd_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end

    assign expire_o = en_i && (wd_cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing the single-ported unified RAM between the instruction cache
// (read-only) and the data cache (read/write). The data cache has priority,
// but after MAX_D_STREAK consecutive data completions with an instruction
// fetch pending, one instruction access is forced. Each granted access is
// guarded by a watchdog; RAM errors and timeouts return ERR_WORD and set a
// sticky error flag.
// Ports:
//   CLK, RST                  clock and synchronous active-high reset
//   iREN, iaddr               icache read request and word address
//   iwait, iload              icache stall (0 only on completion) and data
//   dREN, dWEN, daddr, dstore dcache request (write wins), address, data
//   dwait, dload              dcache stall (0 only on completion) and data
//   ramREN, ramWEN, ramaddr, ramstore   RAM request side
//   ramload, ramstate         RAM read data and handshake state
//   grant_d                   data cache currently owns the RAM
//   err                       sticky error flag
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int          MAX_D_STREAK = 4,
    parameter int          TIMEOUT      = 64,
    parameter logic [31:0] ERR_WORD     = ERR_WORD_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        grant_d,
    output logic        err
);

    localparam int              SW         = $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0]   STREAK_MAX = SW'(MAX_D_STREAK);

    arbstate_t     state_q, state_d;
    logic [SW-1:0] d_streak_q, d_streak_d;
    logic          err_q, err_d;

    ramstate_t ram_st;
    logic      granted, d_req, owner_req;
    logic      expire, done_ok, done_bad, finish;
    logic      wd_clr;
    arbstate_t pick;

    assign ram_st    = ramstate_t'(ramstate);
    assign granted   = (state_q != IDLE);
    assign d_req     = dREN | dWEN;
    assign owner_req = (state_q == GNT_D) ? d_req : ((state_q == GNT_I) ? iREN : 1'b0);

    // ACCESS takes precedence over a timeout landing in the same cycle.
    assign done_ok  = granted && (ram_st == ACCESS);
    assign done_bad = granted && !done_ok && ((ram_st == ERROR) || expire);
    assign finish   = done_ok | done_bad;

    always_comb begin
        d_streak_d = d_streak_q;
        if (!iREN) begin
            d_streak_d = '0;
        end else if (finish && (state_q == GNT_I)) begin
            d_streak_d = '0;
        end else if (finish && (state_q == GNT_D) && (d_streak_q != STREAK_MAX)) begin
            d_streak_d = d_streak_q + SW'(1);
        end
    end

    // The post-update streak is used so the forced fetch follows the
    // MAX_D_STREAK-th data completion directly rather than one later.
    always_comb begin
        pick = IDLE;
        if (iREN && (d_streak_d == STREAK_MAX)) begin
            pick = GNT_I;
        end else if (d_req) begin
            pick = GNT_D;
        end else if (iREN) begin
            pick = GNT_I;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!granted || finish) begin
            state_d = pick;
        end else if (!owner_req) begin
            state_d = IDLE;
        end
        err_d = err_q | done_bad;
    end

    assign wd_clr = (state_d != state_q) || finish;

    arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk_i    (CLK),
        .rst_i    (RST),
        .clr_i    (wd_clr),
        .en_i     (granted),
        .expire_o (expire)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            d_streak_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            d_streak_q <= d_streak_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        case (state_q)
            GNT_D: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                if (finish) begin
                    dwait = 1'b0;
                    dload = done_ok ? ramload : ERR_WORD;
                end
            end
            GNT_I: begin
                ramaddr = iaddr;
                ramREN  = 1'b1;
                if (finish) begin
                    iwait = 1'b0;
                    iload = done_ok ? ramload : ERR_WORD;
                end
            end
            default: ;
        endcase
    end

    assign grant_d = (state_q == GNT_D);
    assign err     = err_q;

endmodule
